// File: rtl/traffic_pkg.sv
// Shared types and constants for the opponent-car mover: FSM encoding,
// speed clamp and lane index type.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_e;

    localparam int unsigned MAX_SPEED = 4;

    typedef logic [1:0] lane_idx_t;

    // Pixels moved per frame: clamped speed times two.
    function automatic logic [3:0] speed_step(input logic [2:0] spd);
        logic [2:0] clamped;
        clamped = (spd > 3'(MAX_SPEED)) ? 3'(MAX_SPEED) : spd;
        return {clamped, 1'b0};
    endfunction

endpackage

// File: rtl/traffic_mover_if.sv
// Game-FSM phase inputs and car position outputs of the traffic mover.
// The master side is the game controller; the slave side is the mover.
interface traffic_mover_if;
    logic       frame_tick;
    logic       show_cars;
    logic       beginning;
    logic       game_end;
    logic [2:0] speed;
    logic [9:0] car2_x;
    logic [9:0] car2_y;
    logic [9:0] car3_x;
    logic [9:0] car3_y;
    logic       respawn;
    logic [7:0] score;

    modport master (
        output frame_tick, show_cars, beginning, game_end, speed,
        input  car2_x, car2_y, car3_x, car3_y, respawn, score
    );

    modport slave (
        input  frame_tick, show_cars, beginning, game_end, speed,
        output car2_x, car2_y, car3_x, car3_y, respawn, score
    );
endinterface

// File: rtl/traffic_mover_lfsr_lane.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) and its mapping
// onto a respawn lane index plus the adjacent lane for a second car.
module lfsr_lane
    import traffic_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic      clk,
    input  logic      rst_n,
    output lane_idx_t lane_a,
    output lane_idx_t lane_b
);

    logic [7:0] lfsr;
    logic       feedback;

    assign feedback = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], feedback};
        end
    end

    // Code 3 folds onto the middle lane so only three lanes are produced.
    always_comb begin
        lane_a = 2'd1;
        case (lfsr[1:0])
            2'd0:    lane_a = 2'd0;
            2'd1:    lane_a = 2'd1;
            2'd2:    lane_a = 2'd2;
            default: lane_a = 2'd1;
        endcase
        lane_b = (lane_a == 2'd2) ? 2'd0 : lane_a + 2'd1;
    end

endmodule

// File: rtl/traffic_mover.sv
// Moves opponent cars car2/car3 down the road once per frame and respawns
// them in LFSR-chosen lanes. Define TRAFFIC_SCORE_EN to enable the score counter.
//
// state  | meaning
// IDLE   | cars parked at home positions, score cleared
// RUN    | cars advance on each frame_tick, respawn at screen bottom
// FROZEN | game over, positions and score hold until beginning
module traffic_mover
    import traffic_pkg::*;
#(
    parameter logic [9:0]  LANE0_X   = 10'd200,
    parameter logic [9:0]  LANE1_X   = 10'd280,
    parameter logic [9:0]  LANE2_X   = 10'd360,
    parameter logic [10:0] SCREEN_H  = 11'd480,
    parameter logic [9:0]  SPAWN_GAP = 10'd240,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input logic            clk,
    input logic            rst_n,
    traffic_mover_if.slave bus
);

    state_e     state;
    state_e     next_state;
    logic       load_home;
    logic       move_en;

    lane_idx_t  lane_a;
    lane_idx_t  lane_b;
    logic [3:0] step;
    logic [10:0] sum2;
    logic [10:0] sum3;
    logic       wrap2;
    logic       wrap3;

    logic [9:0] car2_x_q;
    logic [9:0] car2_y_q;
    logic [9:0] car3_x_q;
    logic [9:0] car3_y_q;
    logic       respawn_q;

    function automatic logic [9:0] lane_to_x(input lane_idx_t idx);
        logic [9:0] x;
        case (idx)
            2'd0:    x = LANE0_X;
            2'd2:    x = LANE2_X;
            default: x = LANE1_X;
        endcase
        return x;
    endfunction

    lfsr_lane #(
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .lane_a (lane_a),
        .lane_b (lane_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (bus.show_cars && !bus.game_end) next_state = ST_RUN;
            end
            ST_RUN: begin
                if (bus.game_end)       next_state = ST_FROZEN;
                else if (bus.beginning) next_state = ST_IDLE;
            end
            ST_FROZEN: begin
                if (bus.beginning) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // game_end wins over both frame_tick and beginning while running.
    always_comb begin
        load_home = 1'b0;
        move_en   = 1'b0;
        case (state)
            ST_IDLE: load_home = 1'b1;
            ST_RUN: begin
                load_home = bus.beginning && !bus.game_end;
                move_en   = bus.frame_tick && !bus.game_end && !bus.beginning;
            end
            ST_FROZEN: load_home = bus.beginning;
            default:   load_home = 1'b1;
        endcase
    end

    assign step  = speed_step(bus.speed);
    assign sum2  = {1'b0, car2_y_q} + {7'd0, step};
    assign sum3  = {1'b0, car3_y_q} + {7'd0, step};
    assign wrap2 = move_en && (step != 4'd0) && (sum2 >= SCREEN_H);
    assign wrap3 = move_en && (step != 4'd0) && (sum3 >= SCREEN_H);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            car2_x_q  <= LANE0_X;
            car2_y_q  <= '0;
            car3_x_q  <= LANE2_X;
            car3_y_q  <= SPAWN_GAP;
            respawn_q <= 1'b0;
        end else if (load_home) begin
            car2_x_q  <= LANE0_X;
            car2_y_q  <= '0;
            car3_x_q  <= LANE2_X;
            car3_y_q  <= SPAWN_GAP;
            respawn_q <= 1'b0;
        end else begin
            respawn_q <= wrap2 | wrap3;
            if (wrap2) begin
                car2_y_q <= '0;
                car2_x_q <= lane_to_x(lane_a);
            end else if (move_en) begin
                car2_y_q <= sum2[9:0];
            end
            // Simultaneous respawn pushes car3 into the neighbouring lane.
            if (wrap3) begin
                car3_y_q <= '0;
                car3_x_q <= wrap2 ? lane_to_x(lane_b) : lane_to_x(lane_a);
            end else if (move_en) begin
                car3_y_q <= sum3[9:0];
            end
        end
    end

    assign bus.car2_x  = car2_x_q;
    assign bus.car2_y  = car2_y_q;
    assign bus.car3_x  = car3_x_q;
    assign bus.car3_y  = car3_y_q;
    assign bus.respawn = respawn_q;

`ifdef TRAFFIC_SCORE_EN
    logic [7:0] score_q;
    logic [8:0] score_sum;

    assign score_sum = {1'b0, score_q} + {8'd0, wrap2} + {8'd0, wrap3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q <= '0;
        end else if (load_home) begin
            score_q <= '0;
        end else if (score_sum[8]) begin
            score_q <= 8'hFF;
        end else begin
            score_q <= score_sum[7:0];
        end
    end

    assign bus.score = score_q;
`else
    assign bus.score = 8'd0;
`endif

endmodule

// File: tb/tb_traffic_mover.sv
// Scoreboard bench for traffic_mover: stimulus pushes expected car state,
// a negedge monitor pops and compares one clk after each tick or sample request.
module tb_traffic_mover;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    traffic_mover_if bus();

    traffic_mover dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // k: 0 = exact x expected, 1 = x must be one of the three lanes
    typedef struct {
        logic [9:0] x2, y2, x3, y3;
        logic [1:0] k2, k3;
        logic       distinct;
        logic       respawn;
        logic [7:0] score;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    logic sample_req = 1'b0;
    logic req_q = 1'b0;

    int         m_st;
    logic [9:0] m_x2, m_y2, m_x3, m_y3;
    logic [1:0] m_k2, m_k3;
    int         m_score;
    logic       d_show, d_beg, d_end;
    logic [2:0] d_spd;

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_lane(input string name, input int act);
        checks++;
        if (!(act == 200 || act == 280 || act == 360)) begin
            failures++;
            $display("FAIL %s: got %0d expected one of 200/280/360", name, act);
        end
    endtask

    always @(posedge clk) req_q <= bus.frame_tick | sample_req;

    always @(negedge clk) begin
        if (req_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty: got output expected a queued record");
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("car2_y", int'(bus.car2_y), int'(mon_e.y2));
                check_eq("car3_y", int'(bus.car3_y), int'(mon_e.y3));
                if (mon_e.k2 == 2'd0) check_eq("car2_x", int'(bus.car2_x), int'(mon_e.x2));
                else                  check_lane("car2_x_lane", int'(bus.car2_x));
                if (mon_e.k3 == 2'd0) check_eq("car3_x", int'(bus.car3_x), int'(mon_e.x3));
                else                  check_lane("car3_x_lane", int'(bus.car3_x));
                if (mon_e.distinct) begin
                    checks++;
                    if (bus.car2_x == bus.car3_x) begin
                        failures++;
                        $display("FAIL lanes_distinct: got car2_x=%0d car3_x=%0d expected different",
                                 bus.car2_x, bus.car3_x);
                    end
                end
                check_eq("respawn", int'(bus.respawn), int'(mon_e.respawn));
                check_eq("score", int'(bus.score), int'(mon_e.score));
            end
        end else if (rst_n) begin
            check_eq("respawn_quiet", int'(bus.respawn), 0);
        end
    end

    task automatic model_home();
        m_x2 = 10'd200; m_y2 = 10'd0;
        m_x3 = 10'd360; m_y3 = 10'd240;
        m_k2 = 2'd0;    m_k3 = 2'd0;
        m_score = 0;
    endtask

    task automatic clk_cycle(input logic tick, input logic chk, output logic both);
        int   nst;
        int   s;
        logic w2, w3;
        exp_t e;
        @(negedge clk);
        bus.frame_tick = tick;
        bus.show_cars  = d_show;
        bus.beginning  = d_beg;
        bus.game_end   = d_end;
        bus.speed      = d_spd;
        sample_req     = chk;
        nst = m_st;
        w2 = 1'b0;
        w3 = 1'b0;
        case (m_st)
            0: if (d_show && !d_end) nst = 1;
            1: if (d_end) nst = 2; else if (d_beg) nst = 0;
            default: if (d_beg) nst = 0;
        endcase
        if (nst == 0) begin
            model_home();
        end else if (m_st == 1 && tick && !d_end) begin
            s = ((d_spd > 3'd4) ? 4 : int'(d_spd)) * 2;
            if (s > 0) begin
                if (int'(m_y2) + s >= 480) begin w2 = 1'b1; m_y2 = 10'd0; m_k2 = 2'd1; end
                else m_y2 = m_y2 + 10'(s);
                if (int'(m_y3) + s >= 480) begin w3 = 1'b1; m_y3 = 10'd0; m_k3 = 2'd1; end
                else m_y3 = m_y3 + 10'(s);
            end
`ifdef TRAFFIC_SCORE_EN
            m_score = m_score + int'(w2) + int'(w3);
            if (m_score > 255) m_score = 255;
`endif
        end
        m_st = nst;
        both = w2 & w3;
        if (tick || chk) begin
            e.x2 = m_x2; e.y2 = m_y2; e.x3 = m_x3; e.y3 = m_y3;
            e.k2 = m_k2; e.k3 = m_k3;
            e.distinct = w2 & w3;
            e.respawn  = w2 | w3;
            e.score    = 8'(m_score);
            exp_q.push_back(e);
        end
    endtask

    task automatic frame(output logic both);
        logic unused_b;
        clk_cycle(1'b1, 1'b0, both);
        clk_cycle(1'b0, 1'b0, unused_b);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected bench to finish");
        $fatal(1);
    end

    initial begin
        logic b;
        logic got_both;
        exp_t e;
        bus.frame_tick = 1'b0;
        bus.show_cars  = 1'b0;
        bus.beginning  = 1'b0;
        bus.game_end   = 1'b0;
        bus.speed      = 3'd0;
        d_show = 1'b0; d_beg = 1'b0; d_end = 1'b0; d_spd = 3'd0;
        m_st = 0;
        model_home();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state, then ticks while parked
        clk_cycle(1'b0, 1'b1, b);
        frame(b);
        frame(b);

        // Slow run: 10 ticks at speed 1
        d_show = 1'b1; d_spd = 3'd1;
        clk_cycle(1'b0, 1'b1, b);
        repeat (10) frame(b);

        // Restart, then full speed until car2 respawns from 472
        d_beg = 1'b1;
        clk_cycle(1'b0, 1'b1, b);
        d_beg = 1'b0;
        clk_cycle(1'b0, 1'b1, b);
        d_spd = 3'd4;
        repeat (60) frame(b);

        // Steer speeds so car3 loses 6 px per wrap until both wrap together
        got_both = 1'b0;
        for (int i = 0; i < 4000 && !got_both; i++) begin
            if (m_y3 == 10'd478)                      d_spd = 3'd4;
            else if (m_y2 >= 10'd464 || m_y3 >= 10'd464) d_spd = 3'd1;
            else                                      d_spd = 3'd4;
            frame(got_both);
        end
        if (!got_both) begin
            failures++;
            $display("FAIL both_respawn_bound: got no double respawn expected one within 4000 frames");
        end

        // game_end coincident with tick freezes everything
        d_end = 1'b1;
        frame(b);
        repeat (100) frame(b);
        d_beg = 1'b1;
        clk_cycle(1'b0, 1'b1, b);
        d_beg = 1'b0;
        clk_cycle(1'b0, 1'b1, b);
        d_end = 1'b0;
        clk_cycle(1'b0, 1'b1, b);

        // Speed clamp, then speed 0 holds position
        d_spd = 3'd7;
        frame(b);
        d_spd = 3'd0;
        repeat (50) frame(b);
        d_spd = 3'd2;
        repeat (5) frame(b);

        // Asynchronous reset between clock edges
        @(negedge clk);
        bus.frame_tick = 1'b0;
        sample_req = 1'b1;
        e.x2 = 10'd200; e.y2 = 10'd0; e.x3 = 10'd360; e.y3 = 10'd240;
        e.k2 = 2'd0; e.k3 = 2'd0; e.distinct = 1'b0; e.respawn = 1'b0; e.score = 8'd0;
        exp_q.push_back(e);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        sample_req = 1'b0;
        m_st = 0;
        model_home();
        d_show = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clk_cycle(1'b0, 1'b1, b);
        repeat (3) clk_cycle(1'b0, 1'b0, b);

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: got %0d records expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
